// File: rtl/mmio_pkg.sv
// Shared definitions for the mmio_bus memory-mapped bus: peripheral register
// offsets (relative to PERIPH_BASE), TCON bit positions and the region select.
package mmio_pkg;

    localparam logic [31:0] TH_OFF     = 32'h00;
    localparam logic [31:0] TL_OFF     = 32'h04;
    localparam logic [31:0] TCON_OFF   = 32'h08;
    localparam logic [31:0] LED_OFF    = 32'h0C;
    localparam logic [31:0] BCD7_OFF   = 32'h10;
    localparam logic [31:0] SYSCLK_OFF = 32'h14;

    localparam int TCON_EN   = 0;
    localparam int TCON_MASK = 1;
    localparam int TCON_STAT = 2;

    typedef enum logic [2:0] {
        SEL_DMEM,
        SEL_TIMER,
        SEL_LED,
        SEL_BCD7,
        SEL_SYSCLK,
        SEL_NONE
    } sel_t;

endpackage

// File: rtl/mmio_timer.sv
// Reloadable 32-bit timer: TH (reload), TL (counter), TCON (enable/mask/status).
// A CPU write to TL beats the increment/reload of the same cycle; an overflow
// setting TCON status beats a TCON write clearing it.
// Optional macro TIMER_IRQ_EN enables the status flag and irq; without it the
// status bit stays 0 and irq is tied low, while reload still works.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic overflow;
    logic stat_next;

    // Overflow happens on the cycle the enabled counter sits at all-ones.
    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

`ifdef TIMER_IRQ_EN
    // Status: cleared by a TCON write with bit 2 low, set by a masked overflow; set wins.
    always_comb begin
        stat_next = tcon[TCON_STAT];
        if (wr_tcon && !wdata[TCON_STAT]) stat_next = 1'b0;
        if (overflow && tcon[TCON_MASK])  stat_next = 1'b1;
    end

    assign irq = tcon[TCON_MASK] & tcon[TCON_STAT];
`else
    assign stat_next = 1'b0;
    assign irq       = 1'b0;
`endif

    // Reload register, written only by the CPU.
    always_ff @(posedge clk) begin
        if (reset)      th <= 32'd0;
        else if (wr_th) th <= wdata;
    end

    // Counter: CPU write first, else count or reload while enabled, else hold.
    always_ff @(posedge clk) begin
        if (reset)               tl <= 32'd0;
        else if (wr_tl)          tl <= wdata;
        else if (tcon[TCON_EN])  tl <= overflow ? th : tl + 32'd1;
    end

    // Control: enable and mask load from the CPU; status follows stat_next.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= 3'd0;
        end else begin
            tcon[TCON_STAT] <= stat_next;
            if (wr_tcon) begin
                tcon[TCON_MASK] <= wdata[TCON_MASK];
                tcon[TCON_EN]   <= wdata[TCON_EN];
            end
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// MEM-stage bus: data memory at byte 0 .. DMEM_WORDS*4-1, and a peripheral
// page at PERIPH_BASE (timer, LED, BCD7, SYSCLK). Reads are combinational,
// writes and peripheral state update on the rising clock edge.
// Optional macro TIMER_IRQ_EN enables the timer interrupt (see mmio_timer).
// Bus protocol: Mem_rd / Mem_wr are single-cycle strobes with no backpressure;
// a write is committed on the edge where Mem_wr=1, a read returns data in the
// same cycle Mem_rd=1, and a read sees the pre-write value of a colliding write.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int          DMEM_WORDS  = 512,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter int          NUM_LED     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic               Mem_rd,
    input  logic               Mem_wr,
    input  logic [31:0]        Write_data,
    output logic [31:0]        Read_data,
    output logic [NUM_LED-1:0] leds,
    output logic [11:0]        digits,
    output logic               irq
);

    localparam int          IDX_W      = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    logic [31:0]        mem [DMEM_WORDS];
    logic [IDX_W-1:0]   idx;
    logic [31:0]        off;
    sel_t               sel;
    logic [NUM_LED-1:0] led_q;
    logic [11:0]        bcd7_q;
    logic [31:0]        sysclk_q;
    logic               wr_timer;
    logic [31:0]        th, tl;
    logic [2:0]         tcon;

    assign idx = addr[IDX_W+1:2];
    assign off = {addr[31:2], 2'b00} - PERIPH_BASE;

    // Address decode: data memory takes precedence, then the peripheral page.
    always_comb begin
        sel = SEL_NONE;
        if (addr < DMEM_BYTES) begin
            sel = SEL_DMEM;
        end else begin
            case (off)
                TH_OFF, TL_OFF, TCON_OFF: sel = SEL_TIMER;
                LED_OFF:                  sel = SEL_LED;
                BCD7_OFF:                 sel = SEL_BCD7;
                SYSCLK_OFF:               sel = SEL_SYSCLK;
                default:                  sel = SEL_NONE;
            endcase
        end
    end

    assign wr_timer = Mem_wr && (sel == SEL_TIMER);

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_timer && (off == TH_OFF)),
        .wr_tl   (wr_timer && (off == TL_OFF)),
        .wr_tcon (wr_timer && (off == TCON_OFF)),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (Mem_wr && (sel == SEL_DMEM)) mem[idx] <= Write_data;
    end

    // LED and 7-segment registers drive their ports directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q  <= '0;
            bcd7_q <= 12'd0;
        end else if (Mem_wr) begin
            if (sel == SEL_LED)  led_q  <= Write_data[NUM_LED-1:0];
            if (sel == SEL_BCD7) bcd7_q <= Write_data[11:0];
        end
    end

    // Free-running cycle counter, read-only from the bus.
    always_ff @(posedge clk) begin
        if (reset) sysclk_q <= 32'd0;
        else       sysclk_q <= sysclk_q + 32'd1;
    end

    assign leds   = led_q;
    assign digits = bcd7_q;

    // Read mux: zero unless a read strobe hits a mapped location.
    always_comb begin
        Read_data = 32'd0;
        if (Mem_rd) begin
            case (sel)
                SEL_DMEM:   Read_data = mem[idx];
                SEL_TIMER: begin
                    if (off == TH_OFF)        Read_data = th;
                    else if (off == TL_OFF)   Read_data = tl;
                    else                      Read_data = {29'd0, tcon};
                end
                SEL_LED:    Read_data = 32'(led_q);
                SEL_BCD7:   Read_data = {20'd0, bcd7_q};
                SEL_SYSCLK: Read_data = sysclk_q;
                default:    Read_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus: memory, peripheral registers, SYSCLK,
// timer reload/irq, write collisions and reset mid-count. Expectations follow
// TIMER_IRQ_EN when the bench is compiled with the same macro as the RTL.
module tb_mmio_bus;

    localparam logic [31:0] PB        = 32'h4000_0000;
    localparam logic [31:0] A_TH      = PB + 32'h00;
    localparam logic [31:0] A_TL      = PB + 32'h04;
    localparam logic [31:0] A_TCON    = PB + 32'h08;
    localparam logic [31:0] A_LED     = PB + 32'h0C;
    localparam logic [31:0] A_BCD7    = PB + 32'h10;
    localparam logic [31:0] A_SYSCLK  = PB + 32'h14;

`ifdef TIMER_IRQ_EN
    localparam logic [31:0] EXP_TCON_OVF = 32'h7;
    localparam logic [31:0] EXP_IRQ_OVF  = 32'h1;
`else
    localparam logic [31:0] EXP_TCON_OVF = 32'h3;
    localparam logic [31:0] EXP_IRQ_OVF  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Clock generation
    always #5 clk = ~clk;

    mmio_bus #(.DMEM_WORDS(512), .PERIPH_BASE(PB), .NUM_LED(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .Mem_rd     (Mem_rd),
        .Mem_wr     (Mem_wr),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .leds       (leds),
        .digits     (digits),
        .irq        (irq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard pop: compares the oldest pending expectation with an observed value.
    task automatic sb_compare(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got=%h", tag, got);
        end else begin
            check_val(tag, got, exp_q.pop_front());
        end
    endtask

    // One write: drive at negedge, committed on the following posedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr       = a;
        Write_data = d;
        Mem_wr     = 1'b1;
        @(posedge clk);
        #1;
        Mem_wr     = 1'b0;
    endtask

    // One combinational read, sampled 1 ns after driving the address.
    task automatic bus_read(input string tag, input logic [31:0] a, input logic rd,
                            input logic [31:0] exp);
        exp_q.push_back(exp);
        addr   = a;
        Mem_rd = rd;
        #1;
        sb_compare(tag, Read_data);
        Mem_rd = 1'b0;
    endtask

    task automatic pin_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        exp_q.push_back(exp);
        sb_compare(tag, got);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        addr       = 32'd0;
        Mem_rd     = 1'b0;
        Mem_wr     = 1'b0;
        Write_data = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        bus_read("rst_th",     A_TH,     1'b1, 32'd0);
        bus_read("rst_tl",     A_TL,     1'b1, 32'd0);
        bus_read("rst_tcon",   A_TCON,   1'b1, 32'd0);
        bus_read("rst_led",    A_LED,    1'b1, 32'd0);
        bus_read("rst_bcd7",   A_BCD7,   1'b1, 32'd0);
        bus_read("rst_sysclk", A_SYSCLK, 1'b1, 32'd0);
        pin_check("rst_leds",   32'(leds),   32'd0);
        pin_check("rst_digits", 32'(digits), 32'd0);
        pin_check("rst_irq",    32'(irq),    32'd0);

        // SYSCLK counts edges after reset release and ignores writes
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus_read("sysclk_10", A_SYSCLK, 1'b1, 32'd10);
        bus_write(A_SYSCLK, 32'h55);
        bus_read("sysclk_wr_ignored", A_SYSCLK, 1'b1, 32'd11);

        // Data memory
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_read("mem_rd_10", 32'h10, 1'b1, 32'hDEAD_BEEF);
        bus_read("mem_rd_13", 32'h13, 1'b1, 32'hDEAD_BEEF);
        bus_read("mem_rd_off", 32'h10, 1'b0, 32'd0);
        bus_write(32'h0, 32'h1111_1111);
        bus_write(32'h800, 32'h2222_2222);
        bus_read("mem_no_alias", 32'h0, 1'b1, 32'h1111_1111);
        bus_read("unmapped_800", 32'h800, 1'b1, 32'd0);
        bus_read("unmapped_pb20", PB + 32'h20, 1'b1, 32'd0);

        // Same-cycle read and write returns the old word
        @(negedge clk);
        addr       = 32'h10;
        Write_data = 32'h1234_5678;
        Mem_wr     = 1'b1;
        Mem_rd     = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        sb_compare("rw_collide_old", Read_data);
        @(posedge clk);
        #1;
        Mem_wr = 1'b0;
        Mem_rd = 1'b0;
        bus_read("rw_collide_new", 32'h10, 1'b1, 32'h1234_5678);

        // LED and BCD7
        bus_write(A_LED, 32'h1A5);
        pin_check("leds_pin", 32'(leds), 32'hA5);
        bus_read("led_rd", A_LED, 1'b1, 32'hA5);
        bus_write(A_BCD7, 32'hF3F);
        pin_check("digits_pin", 32'(digits), 32'hF3F);
        bus_read("bcd7_rd", A_BCD7, 1'b1, 32'hF3F);

        // Timer reload and irq
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        bus_read("tl_reload", A_TL, 1'b1, 32'hFFFF_FFFC);
        bus_read("tcon_ovf", A_TCON, 1'b1, EXP_TCON_OVF);
        pin_check("irq_ovf", 32'(irq), EXP_IRQ_OVF);
        bus_write(A_TCON, 32'h3);
        pin_check("irq_cleared", 32'(irq), 32'd0);
        bus_read("tcon_cleared", A_TCON, 1'b1, 32'h3);

        // TL write on the overflow cycle wins over reload
        bus_write(A_TCON, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h1);
        bus_write(A_TL, 32'h5);
        bus_read("tl_write_wins", A_TL, 1'b1, 32'h5);

        // TCON write on the overflow cycle: status set wins
        bus_write(A_TCON, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h3);
        bus_write(A_TCON, 32'h3);
        bus_read("tcon_set_wins", A_TCON, 1'b1, EXP_TCON_OVF);
        bus_read("tl_reload2", A_TL, 1'b1, 32'hFFFF_FFFC);
        pin_check("irq_set_wins", 32'(irq), EXP_IRQ_OVF);

        // Reset mid-count
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus_read("mid_rst_th",     A_TH,     1'b1, 32'd0);
        bus_read("mid_rst_tl",     A_TL,     1'b1, 32'd0);
        bus_read("mid_rst_tcon",   A_TCON,   1'b1, 32'd0);
        pin_check("mid_rst_irq",    32'(irq),    32'd0);
        pin_check("mid_rst_leds",   32'(leds),   32'd0);
        pin_check("mid_rst_digits", 32'(digits), 32'd0);
        @(negedge clk);
        bus_read("mid_rst_led",    A_LED,    1'b1, 32'd0);
        bus_read("mid_rst_bcd7",   A_BCD7,   1'b1, 32'd0);
        bus_read("mid_rst_sysclk", A_SYSCLK, 1'b1, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus_read("timer_stopped", A_TL, 1'b1, 32'd0);
        bus_read("mem_kept", 32'h10, 1'b1, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Second-generation memory-mapped bus for the pipelined CPU's MEM stage.
- Decodes one word address into two regions:
  - parametrised data memory;
  - a peripheral page with a reloadable timer, LED register, 7-segment register and free-running system clock counter.
- Read path is combinational, so the pipeline keeps single-cycle MEM.
- All writes and peripheral state update on the rising edge of `clk`.

Parameters:
- DMEM_WORDS, 512: data memory depth in 32-bit words. Byte range is 0 .. DMEM_WORDS*4-1.
- PERIPH_BASE, 32'h40000000: base of the peripheral page.
- NUM_LED, 8: width of the LED register and port (1..32).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  byte address; bits [1:0] ignored
- Mem_rd  in  1  read strobe
- Mem_wr  in  1  write strobe
- Write_data  in  32  store data
- Read_data  out  32  load data, combinational
- leds  out  NUM_LED  LED register
- digits  out  12  [7:0] segments, [11:8] anode select
- irq  out  1  timer interrupt request

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports `clk` and `reset`.
- Address map, offsets from PERIPH_BASE:
  - +0x00 TH: timer reload value, R/W.
  - +0x04 TL: timer counter, R/W.
  - +0x08 TCON: [0] enable, [1] irq mask, [2] irq status; R/W. Bits [31:3] read 0.
  - +0x0C LED: R/W, low NUM_LED bits.
  - +0x10 BCD7: R/W, low 12 bits.
  - +0x14 SYSCLK: read-only; writes ignored.
  - Every other address outside data memory is unmapped.
- Reset values:
  - TH, TL, TCON, LED, BCD7, SYSCLK = 0.
  - leds = 0, digits = 0, irq = 0.
  - Data memory contents are not cleared by reset.
- Reads:
  - `Read_data` = selected register or memory word when `Mem_rd`=1. Bits above a register's width read 0.
  - `Read_data` = 0 when `Mem_rd`=0 or the address is unmapped.
  - A read and write to the same address in the same cycle returns the old value.
- Writes:
  - Performed on the edge when `Mem_wr`=1.
  - Unmapped writes and writes with `Mem_wr`=0 have no effect.
  - Memory index is addr[log2(DMEM_WORDS)+1:2].
- SYSCLK: +1 every cycle; wraps 32'hFFFFFFFF to 0.
- Timer, evaluated each cycle with TCON[0]=1:
  - TL == 32'hFFFFFFFF: TL <= TH.
  - Otherwise TL <= TL+1.
  - With TCON[0]=0, TL holds.
- Timer priority: a CPU write to TL in the same cycle overrides the increment or reload.
- TCON write:
  - Bits [1:0] load from Write_data.
  - Bit [2] is cleared if Write_data[2]=0; writing 1 never sets it.
  - An overflow in the same cycle as a TCON write leaves bit [2] = 1 (set wins).
- Reset mid-count: the next edge returns every register to 0; the timer stops.
- `leds` = LED register; `digits` = BCD7 register; both are registered outputs with no decode.

Optional Feature:
- Macro: TIMER_IRQ_EN.
- Defined:
  - An overflow (TL==all-ones while enabled) with TCON[1]=1 sets TCON[2].
  - `irq` = TCON[1] & TCON[2].
- Undefined:
  - TCON[2] is never set and reads 0.
  - `irq` is tied to 0.
  - Reload behaviour is unchanged.

Decomposition:
- Package mmio_pkg holds:
  - register offset constants (TH_OFF, TL_OFF, TCON_OFF, LED_OFF, BCD7_OFF, SYSCLK_OFF);
  - TCON bit indices (TCON_EN, TCON_MASK, TCON_STAT);
  - the region-select enum {SEL_DMEM, SEL_TIMER, SEL_LED, SEL_BCD7, SEL_SYSCLK, SEL_NONE}.
- One sub-module, mmio_timer: owns TH/TL/TCON, the write-override priority and the irq logic.
- The top level keeps the decoder, memory, LED, BCD7, SYSCLK and the read mux.

Test Plan:
- Memory: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0013 → same word.
- Peripheral registers:
  - Write 0x1A5 to LED with NUM_LED=8 → leds = 0xA5, read-back = 0x000000A5.
  - Write 0xF3F to BCD7 → digits = 0xF3F.
- SYSCLK: release reset, read SYSCLK 10 cycles later → 10. Write 0x55 to SYSCLK → value unaffected.
- Timer reload and irq:
  - Setup: TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3, TIMER_IRQ_EN defined.
  - After 2 cycles: TL=0xFFFFFFFC, TCON=7, irq=1.
  - Write TCON=3 → irq=0.
  - Without the macro: TCON stays 3 and irq stays 0.
- Collisions:
  - TL write of 5 on the overflow cycle → TL=5.
  - TCON write of 3 on the overflow cycle → TCON[2]=1.
  - Read of 0x4000_0020 or of DMEM_WORDS*4 → 0.
  - Assert reset mid-count → all registers 0 on the next edge.
